// File: rtl/mc_proc16_pkg.sv
// Shared constants, step enum and opcode helpers for the mc_proc16 processor.
// ALU_SHIFT_EN enables the sll/srl opcodes; without it they decode as no-ops.
package mc_proc16_pkg;

  localparam int N_DEF   = 16;
  localparam int PCW_DEF = 6;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_ST   = 4'd1;
  localparam logic [3:0] OP_MVNZ = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;
  localparam logic [3:0] OP_MVI  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

  function automatic logic is_alu(input logic [3:0] op);
`ifdef ALU_SHIFT_EN
    return (op >= OP_ADD) && (op <= OP_SRL);
`else
    return (op >= OP_ADD) && (op <= OP_SLT);
`endif
  endfunction

  function automatic logic [2:0] alu_sel_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      OP_SLL:  return ALU_SLL;
      OP_SRL:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_proc16_alu.sv
// Combinational ALU for mc_proc16: add, sub, or, unsigned slt and shifts.
// Shift select codes return 0 unless ALU_SHIFT_EN is defined.
module mc_proc16_alu
  import mc_proc16_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [2:0]   sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result
);

  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = (a < b) ? N'(1) : '0;
`ifdef ALU_SHIFT_EN
      ALU_SLL: result = a << b[3:0];
      ALU_SRL: result = a >> b[3:0];
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mc_proc16.sv
// Multicycle 16-bit register-transfer processor: R0-R6 plus PC as R7 on one shared bus.
// Step T0 fetches; T1..T3 execute. Optional shift ops via ALU_SHIFT_EN.
module mc_proc16
  import mc_proc16_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int PCW = PCW_DEF
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           Run,
  input  logic [N-1:0]   DIN,
  input  logic [N-1:0]   MemoryIn,
  output logic           Done,
  output logic [N-1:0]   BusWires,
  output logic [PCW-1:0] PC,
  output logic [N-1:0]   addrM,
  output logic [N-1:0]   doutM,
  output logic           enableMemory,
  output logic [1:0]     step
);

  step_t          step_q, step_d;
  logic [9:0]     ir;
  logic [N-1:0]   r [0:6];
  logic [N-1:0]   a_q, g_q, alu_out, bus;
  logic [PCW-1:0] pc;
  logic [3:0]     opcode;
  logic [2:0]     x, y;
  logic [7:0]     x_dec, y_dec, rd_sel;
  logic           sel_din, sel_mem, sel_g;
  logic           ir_load, pc_inc, rx_write, a_load, g_load;
  logic           dout_load, addr_load, mem_wr, done;

  assign opcode = ir[9:6];
  assign x      = ir[5:3];
  assign y      = ir[2:0];
  assign x_dec  = 8'b1 << x;
  assign y_dec  = 8'b1 << y;

  // rd_sel is one-hot over R0..R6 with bit 7 standing for the PC.
  always_comb begin
    bus = '0;
    if (sel_din) bus = bus | DIN;
    if (sel_mem) bus = bus | MemoryIn;
    if (sel_g)   bus = bus | g_q;
    if (rd_sel[7]) bus = bus | {{(N-PCW){1'b0}}, pc};
    for (int i = 0; i < 7; i++)
      if (rd_sel[i]) bus = bus | r[i];
  end

  mc_proc16_alu #(.N(N)) u_alu (
    .sel    (alu_sel_of(opcode)),
    .a      (a_q),
    .b      (bus),
    .result (alu_out)
  );

  always_comb begin
    rd_sel    = 8'b0;
    sel_din   = 1'b0;
    sel_mem   = 1'b0;
    sel_g     = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    rx_write  = 1'b0;
    a_load    = 1'b0;
    g_load    = 1'b0;
    dout_load = 1'b0;
    addr_load = 1'b0;
    mem_wr    = 1'b0;
    done      = 1'b0;
    step_d    = step_q;
    if (Run) begin
      case (step_q)
        T0: begin
          rd_sel[7] = 1'b1;
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
        end
        T1: begin
          case (opcode)
            OP_MV:   begin rd_sel = y_dec; rx_write = 1'b1; done = 1'b1; end
            OP_ST:   begin rd_sel = x_dec; dout_load = 1'b1; end
            OP_MVNZ: begin rd_sel = y_dec; rx_write = (g_q != '0); done = 1'b1; end
            OP_LD:   begin rd_sel = y_dec; addr_load = 1'b1; end
            OP_MVI:  begin sel_din = 1'b1; rx_write = 1'b1; pc_inc = 1'b1; done = 1'b1; end
            default: begin
              if (is_alu(opcode)) begin
                rd_sel = x_dec;
                a_load = 1'b1;
              end else begin
                done = 1'b1;
              end
            end
          endcase
        end
        T2: begin
          if (opcode == OP_ST) begin
            rd_sel    = y_dec;
            addr_load = 1'b1;
            mem_wr    = 1'b1;
            done      = 1'b1;
          end else if (is_alu(opcode)) begin
            rd_sel = y_dec;
            g_load = 1'b1;
          end else if (opcode != OP_LD) begin
            done = 1'b1;
          end
        end
        default: begin
          done = 1'b1;
          if (opcode == OP_LD) begin
            sel_mem  = 1'b1;
            rx_write = 1'b1;
          end else if (is_alu(opcode)) begin
            sel_g    = 1'b1;
            rx_write = 1'b1;
          end
        end
      endcase
      step_d = done ? T0 : step_t'(step_q + 2'd1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      step_q       <= T0;
      ir           <= '0;
      pc           <= '0;
      a_q          <= '0;
      g_q          <= '0;
      addrM        <= '0;
      doutM        <= '0;
      enableMemory <= 1'b0;
      for (int i = 0; i < 7; i++) r[i] <= '0;
    end else begin
      step_q       <= step_d;
      enableMemory <= mem_wr;
      if (ir_load)   ir    <= DIN[15:6];
      if (a_load)    a_q   <= bus;
      if (g_load)    g_q   <= alu_out;
      if (dout_load) doutM <= bus;
      if (addr_load) addrM <= bus;
      // A write targeting R7 replaces the pending PC increment.
      if (rx_write && (x == 3'd7)) pc <= bus[PCW-1:0];
      else if (pc_inc)             pc <= pc + PCW'(1);
      for (int i = 0; i < 7; i++)
        if (rx_write && (x == 3'(i))) r[i] <= bus;
    end
  end

  assign Done     = done;
  assign BusWires = bus;
  assign PC       = pc;
  assign step     = step_q;

endmodule

// File: tb/tb_mc_proc16.sv
// Directed bench for mc_proc16: a table of hand-computed instruction vectors plus
// hand-written sequences for Run hold and mid-instruction reset. Honors ALU_SHIFT_EN.
`timescale 1ns/1ps
module tb_mc_proc16;
  import mc_proc16_pkg::*;

  logic        Clock = 1'b0;
  logic        Resetn, Run;
  logic [15:0] DIN, MemoryIn;
  logic        Done, enableMemory;
  logic [15:0] BusWires, addrM, doutM;
  logic [5:0]  PC;
  logic [1:0]  step;

  logic [15:0] imem [0:63];
  logic [15:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  assign DIN = imem[PC];

  mc_proc16 dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .MemoryIn(MemoryIn),
    .Done(Done), .BusWires(BusWires), .PC(PC), .addrM(addrM), .doutM(doutM),
    .enableMemory(enableMemory), .step(step)
  );

  // Clock / watchdog
  always #5 Clock = ~Clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] mem_in;
    logic [15:0] exp_bus;
    int          exp_steps;
    logic [5:0]  exp_pc;
    bit          mem_chk;
    logic [15:0] exp_addr;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs [$];

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {op, rx, ry, 6'b0};
  endfunction

  function automatic vec_t mk(input logic [15:0] instr, input logic [15:0] imm, input logic [15:0] mem_in,
                              input logic [15:0] exp_bus, input int exp_steps, input logic [5:0] exp_pc);
    vec_t v;
    v.instr = instr; v.imm = imm; v.mem_in = mem_in; v.exp_bus = exp_bus;
    v.exp_steps = exp_steps; v.exp_pc = exp_pc;
    v.mem_chk = 1'b0; v.exp_addr = '0; v.exp_dout = '0;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: place one instruction at start_pc, step until Done, land in next T0.
  task automatic run_vec(input vec_t v, input logic [5:0] start_pc);
    int n;
    logic [15:0] exp;
    imem[start_pc]         = v.instr;
    imem[start_pc + 6'd1]  = v.imm;
    MemoryIn = v.mem_in;
    Run = 1'b1;
    #1;
    check("pc_start", {10'b0, PC}, {10'b0, start_pc});
    check("done_t0", {15'b0, Done}, 16'd0);
    exp_q.push_back(v.exp_bus);
    n = 0;
    do begin
      @(posedge Clock); @(negedge Clock); #1;
      n++;
    end while (!Done && n < 6);
    check("steps", 16'(n), 16'(v.exp_steps));
    exp = exp_q.pop_front();
    check("bus_done", BusWires, exp);
    @(posedge Clock); @(negedge Clock); #1;
    check("pc_after", {10'b0, PC}, {10'b0, v.exp_pc});
    if (v.mem_chk) begin
      check("st_addr", addrM, v.exp_addr);
      check("st_dout", doutM, v.exp_dout);
      check("st_en_hi", {15'b0, enableMemory}, 16'd1);
      Run = 1'b0;
      @(posedge Clock); @(negedge Clock); #1;
      check("st_en_lo", {15'b0, enableMemory}, 16'd0);
      Run = 1'b1;
    end
  endtask

  initial begin
    vec_t v;
    logic [5:0] pc_m;
    for (int i = 0; i < 64; i++) imem[i] = '0;
    MemoryIn = '0;
    Run = 1'b0;
    Resetn = 1'b1;

    // Reset
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b0;
    #1;
    check("rst_pc", {10'b0, PC}, 16'd0);
    check("rst_done", {15'b0, Done}, 16'd0);
    check("rst_bus", BusWires, 16'd0);
    check("rst_addr", addrM, 16'd0);
    check("rst_dout", doutM, 16'd0);
    check("rst_en", {15'b0, enableMemory}, 16'd0);
    check("rst_step", {14'b0, step}, 16'd0);

    vecs.push_back(mk(enc(OP_MVI, 1, 0), 16'h00A5, 0, 16'h00A5, 1, 6'd2));
    vecs.push_back(mk(enc(OP_MV, 0, 1), 0, 0, 16'h00A5, 1, 6'd3));
    vecs.push_back(mk(enc(OP_MVI, 1, 0), 16'h0005, 0, 16'h0005, 1, 6'd5));
    vecs.push_back(mk(enc(OP_MVI, 2, 0), 16'h0003, 0, 16'h0003, 1, 6'd7));
    vecs.push_back(mk(enc(OP_ADD, 1, 2), 0, 0, 16'h0008, 3, 6'd8));
    vecs.push_back(mk(enc(OP_SUB, 1, 2), 0, 0, 16'h0005, 3, 6'd9));
    vecs.push_back(mk(enc(OP_MVI, 3, 0), 16'h0003, 0, 16'h0003, 1, 6'd11));
    vecs.push_back(mk(enc(OP_SLT, 3, 1), 0, 0, 16'h0001, 3, 6'd12));
    vecs.push_back(mk(enc(OP_MVI, 4, 0), 16'h0005, 0, 16'h0005, 1, 6'd14));
    vecs.push_back(mk(enc(OP_SLT, 4, 2), 0, 0, 16'h0000, 3, 6'd15));
    vecs.push_back(mk(enc(OP_MVI, 5, 0), 16'h0001, 0, 16'h0001, 1, 6'd17));
    vecs.push_back(mk(enc(OP_MVI, 6, 0), 16'h0004, 0, 16'h0004, 1, 6'd19));
`ifdef ALU_SHIFT_EN
    vecs.push_back(mk(enc(OP_SLL, 5, 6), 0, 0, 16'h0010, 3, 6'd20));
`else
    vecs.push_back(mk(enc(OP_SLL, 5, 6), 0, 0, 16'h0000, 1, 6'd20));
`endif
    vecs.push_back(mk(enc(OP_MVI, 5, 0), 16'h8000, 0, 16'h8000, 1, 6'd22));
    vecs.push_back(mk(enc(OP_MVI, 6, 0), 16'h000F, 0, 16'h000F, 1, 6'd24));
`ifdef ALU_SHIFT_EN
    vecs.push_back(mk(enc(OP_SRL, 5, 6), 0, 0, 16'h0001, 3, 6'd25));
`else
    vecs.push_back(mk(enc(OP_SRL, 5, 6), 0, 0, 16'h0000, 1, 6'd25));
`endif
    vecs.push_back(mk(enc(OP_MVI, 1, 0), 16'h1234, 0, 16'h1234, 1, 6'd27));
    vecs.push_back(mk(enc(OP_MVI, 2, 0), 16'h0010, 0, 16'h0010, 1, 6'd29));
    v = mk(enc(OP_ST, 1, 2), 0, 0, 16'h0010, 2, 6'd30);
    v.mem_chk = 1'b1; v.exp_addr = 16'h0010; v.exp_dout = 16'h1234;
    vecs.push_back(v);
    vecs.push_back(mk(enc(OP_LD, 3, 2), 0, 16'hBEEF, 16'hBEEF, 3, 6'd31));
    vecs.push_back(mk(enc(OP_MV, 0, 3), 0, 0, 16'hBEEF, 1, 6'd32));
    vecs.push_back(mk(enc(OP_SUB, 4, 4), 0, 0, 16'h0000, 3, 6'd33));
    vecs.push_back(mk(enc(OP_MVI, 5, 0), 16'h0077, 0, 16'h0077, 1, 6'd35));
    vecs.push_back(mk(enc(OP_MVNZ, 6, 5), 0, 0, 16'h0077, 1, 6'd36));
    vecs.push_back(mk(enc(OP_MV, 0, 6), 0, 0, 16'h000F, 1, 6'd37));
    vecs.push_back(mk(enc(OP_ADD, 1, 2), 0, 0, 16'h1244, 3, 6'd38));
    vecs.push_back(mk(enc(OP_MVNZ, 6, 5), 0, 0, 16'h0077, 1, 6'd39));
    vecs.push_back(mk(enc(OP_MV, 0, 6), 0, 0, 16'h0077, 1, 6'd40));
    vecs.push_back(mk(enc(OP_MVI, 4, 0), 16'h0003, 0, 16'h0003, 1, 6'd42));
    vecs.push_back(mk(enc(OP_MV, 7, 4), 0, 0, 16'h0003, 1, 6'd3));
    vecs.push_back(mk(enc(OP_MVI, 7, 0), 16'h003F, 0, 16'h003F, 1, 6'd63));
    vecs.push_back(mk(enc(OP_MV, 0, 0), 0, 0, 16'h0077, 1, 6'd0));
    vecs.push_back(mk(enc(4'd11, 0, 0), 0, 0, 16'h0000, 1, 6'd1));
    vecs.push_back(mk(enc(4'd15, 0, 0), 0, 0, 16'h0000, 1, 6'd2));
    vecs.push_back(mk(enc(OP_MV, 0, 7), 0, 0, 16'h0003, 1, 6'd3));

    pc_m = 6'd0;
    foreach (vecs[i]) begin
      run_vec(vecs[i], pc_m);
      pc_m = vecs[i].exp_pc;
    end

    // Run = 0 holds the step counter and deasserts every control
    imem[3] = enc(OP_MV, 0, 1);
    Run = 1'b1;
    @(posedge Clock); @(negedge Clock);
    Run = 1'b0;
    #1;
    check("hold_done", {15'b0, Done}, 16'd0);
    check("hold_bus", BusWires, 16'd0);
    @(posedge Clock); @(negedge Clock); #1;
    check("hold_step", {14'b0, step}, 16'd1);
    check("hold_pc", {10'b0, PC}, 16'd4);
    Run = 1'b1;
    #1;
    check("resume_done", {15'b0, Done}, 16'd1);
    check("resume_bus", BusWires, 16'h1244);
    @(posedge Clock); @(negedge Clock); #1;
    check("resume_step", {14'b0, step}, 16'd0);

    // Reset in the middle of an ALU instruction
    imem[4] = enc(OP_ADD, 1, 2);
    @(posedge Clock); @(posedge Clock); @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock); @(negedge Clock);
    Resetn = 1'b0;
    #1;
    check("midrst_pc", {10'b0, PC}, 16'd0);
    check("midrst_step", {14'b0, step}, 16'd0);
    check("midrst_addr", addrM, 16'd0);
    check("midrst_dout", doutM, 16'd0);
    run_vec(mk(enc(OP_MV, 0, 1), 0, 0, 16'h0000, 1, 6'd1), 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
